// File: rtl/lsu_ctrl_if.sv
// Data-memory bus between the load/store unit and data memory.
// The master drives the request side; the slave returns the ack and the read data.
interface lsu_ctrl_if;
    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        ack;
    logic [31:0] rdata;

    modport master (output req, we, be, addr, wdata, input ack, rdata);
    modport slave  (input req, we, be, addr, wdata, output ack, rdata);
endinterface

// File: rtl/lsu_ctrl.sv
// Load/store unit controller: decodes core memory ops, runs one data-memory access at a time,
// formats load results and reports misaligned accesses and bus timeouts.
module lsu_ctrl #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        memtoreg,
    input  logic        lbu,
    input  logic [1:0]  memwrite,
    input  logic [1:0]  half,
    input  logic        b,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        stall,
    output logic [31:0] rdata,
    output logic        rdata_valid,
    output logic        misalign,
    output logic        bus_err,
    lsu_ctrl_if.master  dmem
);
    localparam int unsigned CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {st_idle, st_access, st_done} state_e;
    typedef enum logic [1:0] {sz_byte, sz_half, sz_word} size_e;

    state_e        state_q;
    logic [CW-1:0] cnt_q;
    size_e         size_q;
    logic          sgn_q;
    logic          load_q;
    logic [1:0]    lane_q;

    logic        is_store, is_load, op_valid, op_signed, op_misalign, accept;
    size_e       op_size;
    logic [3:0]  op_be;
    logic [31:0] op_wdata;
    logic [7:0]  lane_byte;
    logic [15:0] lane_half;
    logic [31:0] fmt_rdata;

    // Decode of the op currently presented by the core; stores take priority over load flags.
    always_comb begin
        is_store  = memwrite != 2'b00;
        is_load   = !is_store && (memtoreg || lbu);
        op_valid  = is_store || is_load;
        op_size   = sz_word;
        op_signed = 1'b0;
        if (is_store) begin
            case (memwrite)
                2'b10:   op_size = sz_half;
                2'b11:   op_size = sz_byte;
                default: op_size = sz_word;
            endcase
        end else if (lbu) begin
            op_size = sz_byte;
        end else if (half == 2'b01) begin
            op_size   = b ? sz_byte : sz_half;
            op_signed = 1'b1;
        end else if (half == 2'b10) begin
            op_size = sz_half;
        end
        op_misalign = ((op_size == sz_word) && (addr[1:0] != 2'b00)) ||
                      ((op_size == sz_half) && addr[0]);
        accept = (state_q == st_idle) && start && op_valid && !op_misalign;

        case (op_size)
            sz_byte: begin
                op_be    = 4'b0001 << addr[1:0];
                op_wdata = {4{wdata[7:0]}};
            end
            sz_half: begin
                op_be    = addr[1] ? 4'b1100 : 4'b0011;
                op_wdata = {2{wdata[15:0]}};
            end
            default: begin
                op_be    = 4'b1111;
                op_wdata = wdata;
            end
        endcase
        if (!is_store) op_be = 4'b1111;

        // Gated by reset so the core is released the moment reset asserts.
        stall = reset && (accept || (state_q == st_access));
    end

    always_comb begin
        lane_byte = dmem.rdata[{lane_q, 3'b000} +: 8];
        lane_half = dmem.rdata[{lane_q[1], 4'b0000} +: 16];
        case (size_q)
            sz_byte: fmt_rdata = {{24{sgn_q & lane_byte[7]}}, lane_byte};
            sz_half: fmt_rdata = {{16{sgn_q & lane_half[15]}}, lane_half};
            default: fmt_rdata = dmem.rdata;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= st_idle;
            cnt_q       <= '0;
            size_q      <= sz_word;
            sgn_q       <= 1'b0;
            load_q      <= 1'b0;
            lane_q      <= 2'b00;
            rdata       <= '0;
            rdata_valid <= 1'b0;
            misalign    <= 1'b0;
            bus_err     <= 1'b0;
            dmem.req    <= 1'b0;
            dmem.we     <= 1'b0;
            dmem.be     <= '0;
            dmem.addr   <= '0;
            dmem.wdata  <= '0;
        end else begin
            rdata_valid <= 1'b0;
            misalign    <= 1'b0;
            bus_err     <= 1'b0;
            case (state_q)
                st_idle: begin
                    if (start && op_valid && op_misalign) begin
                        misalign <= 1'b1;
                    end else if (accept) begin
                        state_q    <= st_access;
                        cnt_q      <= '0;
                        size_q     <= op_size;
                        sgn_q      <= op_signed;
                        load_q     <= is_load;
                        lane_q     <= addr[1:0];
                        dmem.req   <= 1'b1;
                        dmem.we    <= is_store;
                        dmem.be    <= op_be;
                        dmem.addr  <= {addr[31:2], 2'b00};
                        dmem.wdata <= op_wdata;
                    end
                end
                st_access: begin
                    // An ack in the final counted cycle still completes the access.
                    if (dmem.ack || (cnt_q == CW'(TIMEOUT))) begin
                        state_q    <= dmem.ack ? st_done : st_idle;
                        bus_err    <= !dmem.ack;
                        dmem.req   <= 1'b0;
                        dmem.we    <= 1'b0;
                        dmem.be    <= '0;
                        dmem.addr  <= '0;
                        dmem.wdata <= '0;
                        if (dmem.ack && load_q) begin
                            rdata       <= fmt_rdata;
                            rdata_valid <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: state_q <= st_idle;
            endcase
        end
    end
endmodule

// File: tb/tb_lsu_ctrl.sv
// Self-checking bench for lsu_ctrl: directed op tables, a queue of expected load results,
// and a hand-driven memory responder.
module tb_lsu_ctrl;
    localparam int unsigned TIMEOUT = 255;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        memtoreg = 1'b0;
    logic        lbu = 1'b0;
    logic        b = 1'b0;
    logic [1:0]  memwrite = 2'b00;
    logic [1:0]  half = 2'b00;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic        stall, rdata_valid, misalign, bus_err;
    logic [31:0] rdata;

    lsu_ctrl_if dmem ();

    int          checks = 0;
    int          failures = 0;
    logic [31:0] exp_q[$];
    logic [31:0] last_load_exp = '0;

    typedef struct packed {
        logic        mr;
        logic        lb;
        logic [1:0]  hf;
        logic        bb;
        logic [31:0] a;
        logic [31:0] rd;
        logic [31:0] exp;
    } ld_t;

    typedef struct packed {
        logic [1:0]  mw;
        logic        mr;
        logic [31:0] a;
        logic [31:0] wd;
        logic [3:0]  be;
        logic [31:0] ewd;
    } st_t;

    typedef struct packed {
        logic        mr;
        logic        lb;
        logic [1:0]  mw;
        logic [1:0]  hf;
        logic        bb;
        logic [31:0] a;
        logic        mis;
    } ms_t;

    always #5 clk = ~clk;

    lsu_ctrl #(.TIMEOUT(TIMEOUT)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .memtoreg    (memtoreg),
        .lbu         (lbu),
        .memwrite    (memwrite),
        .half        (half),
        .b           (b),
        .addr        (addr),
        .wdata       (wdata),
        .stall       (stall),
        .rdata       (rdata),
        .rdata_valid (rdata_valid),
        .misalign    (misalign),
        .bus_err     (bus_err),
        .dmem        (dmem)
    );

    task automatic set_op(input logic mr, input logic lb, input logic [1:0] mw,
                          input logic [1:0] hf, input logic bb, input logic [31:0] a,
                          input logic [31:0] wd);
        memtoreg = mr; lbu = lb; memwrite = mw; half = hf; b = bb; addr = a; wdata = wd;
        start = 1'b1;
    endtask

    task automatic clear_op();
        start = 1'b0; memtoreg = 1'b0; lbu = 1'b0; memwrite = 2'b00; half = 2'b00; b = 1'b0;
        addr = '0; wdata = '0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        set_op(1'b1, 1'b0, 2'b00, 2'b00, 1'b0, 32'h100, 32'h0);
        #1;
        checks++;
        if (stall !== 1'b0) begin
            failures++; $display("FAIL reset_stall got=%b want=0", stall);
        end
        @(negedge clk);
        checks++;
        if ({stall, rdata_valid, misalign, bus_err, dmem.req, dmem.we, dmem.be, dmem.addr,
             dmem.wdata, rdata} !== '0) begin
            failures++;
            $display("FAIL reset_outputs got req=%b we=%b be=%h addr=%h wdata=%h rdata=%h want all 0",
                     dmem.req, dmem.we, dmem.be, dmem.addr, dmem.wdata, rdata);
        end
        clear_op();
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if ({dmem.req, stall} !== 2'b00) begin
            failures++; $display("FAIL reset_release_idle got req=%b stall=%b want 0 0",
                                 dmem.req, stall);
        end
    endtask

    task automatic test_loads();
        ld_t tbl[8];
        tbl[0] = '{1'b1, 1'b0, 2'b01, 1'b1, 32'h103, 32'h80AABBCC, 32'hFFFFFF80};
        tbl[1] = '{1'b1, 1'b0, 2'b10, 1'b0, 32'h102, 32'hF00D0000, 32'h0000F00D};
        tbl[2] = '{1'b1, 1'b0, 2'b01, 1'b0, 32'h100, 32'h12348001, 32'hFFFF8001};
        tbl[3] = '{1'b1, 1'b0, 2'b00, 1'b0, 32'h200, 32'hDEADBEEF, 32'hDEADBEEF};
        tbl[4] = '{1'b0, 1'b1, 2'b00, 1'b0, 32'h001, 32'h00008500, 32'h00000085};
        tbl[5] = '{1'b1, 1'b0, 2'b01, 1'b1, 32'h102, 32'h007F0000, 32'h0000007F};
        tbl[6] = '{1'b1, 1'b0, 2'b01, 1'b0, 32'h102, 32'h7ABC0000, 32'h00007ABC};
        tbl[7] = '{1'b0, 1'b1, 2'b01, 1'b1, 32'h002, 32'h00AA0000, 32'h000000AA};
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            set_op(tbl[i].mr, tbl[i].lb, 2'b00, tbl[i].hf, tbl[i].bb, tbl[i].a, 32'h0);
            exp_q.push_back(tbl[i].exp);
            #1;
            checks++;
            if (stall !== 1'b1) begin
                failures++; $display("FAIL load%0d_stall got=%b want=1", i, stall);
            end
            @(negedge clk);
            checks++;
            if ({dmem.req, dmem.we, dmem.be, dmem.addr} !== {2'b10, 4'hF, tbl[i].a[31:2], 2'b00})
            begin
                failures++;
                $display("FAIL load%0d_bus got req=%b we=%b be=%h addr=%h want 1 0 f %h", i,
                         dmem.req, dmem.we, dmem.be, dmem.addr, {tbl[i].a[31:2], 2'b00});
            end
            dmem.rdata = tbl[i].rd;
            dmem.ack   = 1'b1;
            @(negedge clk);
            dmem.ack = 1'b0;
            clear_op();
            checks++;
            if ({rdata_valid, stall} !== 2'b10) begin
                failures++; $display("FAIL load%0d_valid got valid=%b stall=%b want 1 0", i,
                                     rdata_valid, stall);
            end
            if (rdata_valid === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++; $display("FAIL load%0d_unexpected got rdata=%h want none", i, rdata);
                end else begin
                    last_load_exp = exp_q.pop_front();
                    if (rdata !== last_load_exp) begin
                        failures++; $display("FAIL load%0d_rdata got=%h want=%h", i, rdata,
                                             last_load_exp);
                    end
                end
            end
            @(negedge clk);
            checks++;
            if ({rdata_valid, rdata} !== {1'b0, tbl[i].exp}) begin
                failures++; $display("FAIL load%0d_hold got valid=%b rdata=%h want 0 %h", i,
                                     rdata_valid, rdata, tbl[i].exp);
            end
        end
    endtask

    task automatic test_stores();
        st_t tbl[5];
        tbl[0] = '{2'b10, 1'b0, 32'h202, 32'h1234ABCD, 4'b1100, 32'hABCDABCD};
        tbl[1] = '{2'b11, 1'b1, 32'h201, 32'hFFFFFF5A, 4'b0010, 32'h5A5A5A5A};
        tbl[2] = '{2'b01, 1'b0, 32'h300, 32'hCAFEF00D, 4'b1111, 32'hCAFEF00D};
        tbl[3] = '{2'b10, 1'b0, 32'h200, 32'h00001357, 4'b0011, 32'h13571357};
        tbl[4] = '{2'b11, 1'b0, 32'h203, 32'h000000C3, 4'b1000, 32'hC3C3C3C3};
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            set_op(tbl[i].mr, 1'b0, tbl[i].mw, 2'b00, 1'b0, tbl[i].a, tbl[i].wd);
            #1;
            checks++;
            if (stall !== 1'b1) begin
                failures++; $display("FAIL store%0d_stall got=%b want=1", i, stall);
            end
            @(negedge clk);
            checks++;
            if ({dmem.req, dmem.we, dmem.be, dmem.addr, dmem.wdata} !==
                {2'b11, tbl[i].be, tbl[i].a[31:2], 2'b00, tbl[i].ewd}) begin
                failures++;
                $display("FAIL store%0d_bus got req=%b we=%b be=%b addr=%h wdata=%h want 1 1 %b %h %h",
                         i, dmem.req, dmem.we, dmem.be, dmem.addr, dmem.wdata, tbl[i].be,
                         {tbl[i].a[31:2], 2'b00}, tbl[i].ewd);
            end
            dmem.rdata = 32'h0BADF00D;
            dmem.ack   = 1'b1;
            @(negedge clk);
            dmem.ack = 1'b0;
            clear_op();
            checks++;
            if ({rdata_valid, stall, dmem.req, rdata} !== {3'b000, last_load_exp}) begin
                failures++;
                $display("FAIL store%0d_done got valid=%b stall=%b req=%b rdata=%h want 0 0 0 %h",
                         i, rdata_valid, stall, dmem.req, rdata, last_load_exp);
            end
        end
    endtask

    task automatic test_misalign();
        ms_t tbl[7];
        tbl[0] = '{1'b1, 1'b0, 2'b00, 2'b00, 1'b0, 32'h101, 1'b1};
        tbl[1] = '{1'b1, 1'b0, 2'b00, 2'b01, 1'b0, 32'h101, 1'b1};
        tbl[2] = '{1'b1, 1'b0, 2'b00, 2'b10, 1'b0, 32'h103, 1'b1};
        tbl[3] = '{1'b0, 1'b0, 2'b01, 2'b00, 1'b0, 32'h102, 1'b1};
        tbl[4] = '{1'b0, 1'b0, 2'b10, 2'b00, 1'b0, 32'h201, 1'b1};
        tbl[5] = '{1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 32'h101, 1'b0};
        tbl[6] = '{1'b0, 1'b0, 2'b00, 2'b01, 1'b1, 32'h100, 1'b0};
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            set_op(tbl[i].mr, tbl[i].lb, tbl[i].mw, tbl[i].hf, tbl[i].bb, tbl[i].a, 32'h55);
            #1;
            checks++;
            if (stall !== 1'b0) begin
                failures++; $display("FAIL mis%0d_stall got=%b want=0", i, stall);
            end
            @(negedge clk);
            clear_op();
            checks++;
            if ({misalign, dmem.req, bus_err} !== {tbl[i].mis, 2'b00}) begin
                failures++; $display("FAIL mis%0d_pulse got mis=%b req=%b err=%b want %b 0 0", i,
                                     misalign, dmem.req, bus_err, tbl[i].mis);
            end
            @(negedge clk);
            checks++;
            if ({misalign, dmem.req} !== 2'b00) begin
                failures++; $display("FAIL mis%0d_clear got mis=%b req=%b want 0 0", i,
                                     misalign, dmem.req);
            end
        end
    endtask

    task automatic test_done_no_accept();
        @(negedge clk);
        set_op(1'b1, 1'b0, 2'b00, 2'b00, 1'b0, 32'h80, 32'h0);
        exp_q.push_back(32'h55667788);
        @(negedge clk);
        dmem.rdata = 32'h55667788;
        dmem.ack   = 1'b1;
        @(negedge clk);
        dmem.ack = 1'b0;
        // New op presented during the completion cycle must not be taken.
        set_op(1'b0, 1'b0, 2'b01, 2'b00, 1'b0, 32'h84, 32'h77);
        #1;
        checks++;
        if ({rdata_valid, stall} !== 2'b10) begin
            failures++; $display("FAIL done_stall got valid=%b stall=%b want 1 0", rdata_valid, stall);
        end
        if (exp_q.size() != 0) last_load_exp = exp_q.pop_front();
        checks++;
        if (rdata !== last_load_exp) begin
            failures++; $display("FAIL done_rdata got=%h want=%h", rdata, last_load_exp);
        end
        @(negedge clk);
        clear_op();
        checks++;
        if (dmem.req !== 1'b0) begin
            failures++; $display("FAIL done_no_accept got req=%b want=0", dmem.req);
        end
    endtask

    task automatic test_ack_idle();
        @(negedge clk);
        dmem.ack   = 1'b1;
        dmem.rdata = 32'hFFFFFFFF;
        repeat (3) @(negedge clk);
        checks++;
        if ({dmem.req, rdata_valid, bus_err, rdata} !== {3'b000, last_load_exp}) begin
            failures++; $display("FAIL ack_idle got req=%b valid=%b err=%b rdata=%h want 0 0 0 %h",
                                 dmem.req, rdata_valid, bus_err, rdata, last_load_exp);
        end
        dmem.ack = 1'b0;
    endtask

    task automatic test_timeout();
        int k;
        @(negedge clk);
        set_op(1'b1, 1'b0, 2'b00, 2'b00, 1'b0, 32'h40, 32'h0);
        @(negedge clk);
        k = 0;
        while (dmem.req === 1'b1 && k < int'(TIMEOUT) + 10) begin
            k++;
            @(negedge clk);
        end
        clear_op();
        checks++;
        if (k != int'(TIMEOUT) + 1) begin
            failures++; $display("FAIL timeout_req_cycles got=%0d want=%0d", k, TIMEOUT + 1);
        end
        #1;
        checks++;
        if ({bus_err, rdata_valid, stall, dmem.req} !== 4'b1000) begin
            failures++; $display("FAIL timeout_err got err=%b valid=%b stall=%b req=%b want 1 0 0 0",
                                 bus_err, rdata_valid, stall, dmem.req);
        end
        @(negedge clk);
        checks++;
        if ({bus_err, dmem.req} !== 2'b00) begin
            failures++; $display("FAIL timeout_err_clear got err=%b req=%b want 0 0", bus_err, dmem.req);
        end

        set_op(1'b1, 1'b0, 2'b00, 2'b00, 1'b0, 32'h44, 32'h0);
        exp_q.push_back(32'h11223344);
        @(negedge clk);
        k = 0;
        while (dmem.req === 1'b1 && k < int'(TIMEOUT) + 10) begin
            k++;
            if (k == int'(TIMEOUT) + 1) begin
                dmem.rdata = 32'h11223344;
                dmem.ack   = 1'b1;
            end
            @(negedge clk);
        end
        dmem.ack = 1'b0;
        clear_op();
        checks++;
        if ({rdata_valid, bus_err} !== 2'b10 || k != int'(TIMEOUT) + 1) begin
            failures++; $display("FAIL late_ack got valid=%b err=%b req_cycles=%0d want 1 0 %0d",
                                 rdata_valid, bus_err, k, TIMEOUT + 1);
        end
        if (rdata_valid === 1'b1 && exp_q.size() != 0) begin
            last_load_exp = exp_q.pop_front();
            checks++;
            if (rdata !== last_load_exp) begin
                failures++; $display("FAIL late_ack_rdata got=%h want=%h", rdata, last_load_exp);
            end
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        set_op(1'b1, 1'b0, 2'b00, 2'b00, 1'b0, 32'h50, 32'h0);
        @(negedge clk);
        checks++;
        if (dmem.req !== 1'b1) begin
            failures++; $display("FAIL rstmid_access got req=%b want=1", dmem.req);
        end
        reset = 1'b0;
        #1;
        checks++;
        if ({dmem.req, stall, rdata} !== '0) begin
            failures++; $display("FAIL rstmid_async got req=%b stall=%b rdata=%h want 0 0 0",
                                 dmem.req, stall, rdata);
        end
        last_load_exp = '0;
        clear_op();
        @(negedge clk);
        // Reset releases and the next op is presented in the same cycle.
        reset = 1'b1;
        set_op(1'b0, 1'b1, 2'b00, 2'b00, 1'b0, 32'h003, 32'h0);
        exp_q.push_back(32'h0000009E);
        @(negedge clk);
        checks++;
        if ({dmem.req, dmem.addr, dmem.be, rdata_valid, bus_err} !== {1'b1, 32'h0, 4'hF, 2'b00})
        begin
            failures++; $display("FAIL rstmid_lbu_bus got req=%b addr=%h be=%h valid=%b err=%b want 1 0 f 0 0",
                                 dmem.req, dmem.addr, dmem.be, rdata_valid, bus_err);
        end
        dmem.rdata = 32'h9E000000;
        dmem.ack   = 1'b1;
        @(negedge clk);
        dmem.ack = 1'b0;
        clear_op();
        checks++;
        if (rdata_valid !== 1'b1 || exp_q.size() == 0) begin
            failures++; $display("FAIL rstmid_lbu_valid got valid=%b queued=%0d want 1 1",
                                 rdata_valid, exp_q.size());
        end else begin
            last_load_exp = exp_q.pop_front();
            checks++;
            if (rdata !== last_load_exp) begin
                failures++; $display("FAIL rstmid_lbu_rdata got=%h want=%h", rdata, last_load_exp);
            end
        end
    endtask

    initial begin
        dmem.ack   = 1'b0;
        dmem.rdata = '0;
        test_reset();
        test_loads();
        test_stores();
        test_misalign();
        test_done_no_accept();
        test_ack_idle();
        test_timeout();
        test_reset_mid();
        checks++;
        if (exp_q.size() != 0) begin
            failures++; $display("FAIL scoreboard_drain got=%0d want=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/lsu_ctrl.md
LSU_CTRL -- requirements
Module: lsu_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255, max cycles waited for dmem_ack before error.
REQ-002 SHALL have ports: clk  input  1  sole clock, rising edge.
REQ-003 SHALL have: reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have: start  input  1  core presents a memory op this cycle; all core inputs held stable while stall=1.
REQ-005 SHALL have: memtoreg  input  1, lbu  input  1, memwrite  input  2, half  input  2, b  input  1  main-decoder control fields.
REQ-006 SHALL have: addr  input  32  byte address; wdata  input  32  store data (rt).
REQ-007 SHALL have: stall  output  1  freeze core pipeline.
REQ-008 SHALL have: rdata  output  32  formatted load result; rdata_valid  output  1  one-cycle load-complete pulse.
REQ-009 SHALL have: misalign  output  1  and bus_err  output  1  one-cycle abort pulses.
REQ-010 SHALL have: dmem_req  output  1, dmem_we  output  1, dmem_be  output  4, dmem_addr  output  32, dmem_wdata  output  32, dmem_ack  input  1, dmem_rdata  input  32.

Function
REQ-011 SHALL decode op: memwrite 01 word store, 10 half store, 11 byte store; else load if memtoreg|lbu; else no op. Store wins over load flags.
REQ-012 SHALL decode load size: lbu -> byte unsigned; half=01&b -> byte signed; half=01 -> half signed; half=10 -> half unsigned; otherwise word.
REQ-013 SHALL use little-endian lanes: byte k = bits 8k+7:8k at addr[1:0]=k.
REQ-014 SHALL flag misaligned: word with addr[1:0]!=0; half with addr[0]=1.
REQ-015 SHALL implement FSM IDLE, ACCESS, DONE.
REQ-016 IDLE: start with valid op and aligned -> register addr/op/wdata, go ACCESS; misaligned -> misalign=1 next cycle, stay IDLE, no dmem_req; start with no op ignored.
REQ-017 ACCESS: dmem_req=1, dmem_addr={addr[31:2],2'b00}, dmem_we=1 for stores; hold until dmem_ack; on ack go DONE.
REQ-018 SHALL produce dmem_be: word 1111; half 0011 (addr[1]=0) / 1100; byte 0001<<addr[1:0]; loads 1111.
REQ-019 SHALL replicate store data: half {2{wdata[15:0]}}, byte {4{wdata[7:0]}}, word wdata.
REQ-020 SHALL capture and format dmem_rdata on ack: select lane, sign- or zero-extend per REQ-012; rdata holds until next load completes.
REQ-021 DONE: rdata_valid=1 for loads only, stall=0, return IDLE unconditionally; start in DONE is not accepted.
REQ-022 stall SHALL be combinational: 1 when IDLE&start&aligned valid op, or state=ACCESS; 0 otherwise (misaligned start does not stall).
REQ-023 SHALL count ACCESS cycles with a counter; on count=TIMEOUT without ack -> bus_err=1 next cycle, dmem_req drops, go IDLE. Ack on the TIMEOUT cycle itself counts as success.
REQ-024 Minimum latency: start cycle N, dmem_req cycle N+1, ack N+1 -> rdata_valid N+2.
REQ-025 dmem_ack outside ACCESS SHALL be ignored.

Reset
REQ-026 reset low SHALL immediately force IDLE, counter 0, and all outputs 0 (stall, rdata, rdata_valid, misalign, bus_err, dmem_req, dmem_we, dmem_be, dmem_addr, dmem_wdata).
REQ-027 reset mid-ACCESS SHALL abandon the op without rdata_valid or bus_err; first cycle after release is IDLE.

Verification
REQ-028 LB addr=0x103, dmem_rdata=0x80AABBCC, ack one cycle after req -> dmem_be=1111, dmem_addr=0x100, rdata=0xFFFFFF80, rdata_valid pulse at N+2.
REQ-029 SH addr=0x202, wdata=0x1234ABCD -> dmem_we=1, dmem_be=1100, dmem_wdata=0xABCDABCD, no rdata_valid.
REQ-030 LW addr=0x101 -> misalign pulse, stall=0, no dmem_req; LHU addr=0x102, rdata 0xF00D0000 -> rdata=0x0000F00D.
REQ-031 Load with ack withheld -> dmem_req high exactly TIMEOUT+1 cycles, bus_err pulse, return IDLE; ack at cycle TIMEOUT -> success.
REQ-032 reset asserted while in ACCESS -> dmem_req and stall low the same cycle; post-release LBU addr=0x3, rdata=0x9E000000 -> rdata=0x0000009E.
